// File: rtl/dbus_uncached_bridge_pkg.sv
// rtl/dbus_uncached_bridge_pkg.sv - shared dbus/cbus types and bridge FSM state encoding
package dbus_uncached_bridge_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Encoded as beats-minus-one, AXI style.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    msize_t            size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    mlen_t             len;
    axi_burst_type_t   burst;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    UB_IDLE = 2'd0,
    UB_REQ  = 2'd1,
    UB_DONE = 2'd2
  } ubridge_state_t;

endpackage

// File: rtl/dbus_uncached_bridge.sv
// rtl/dbus_uncached_bridge.sv - single-beat dbus to cbus bridge for uncached/MMIO accesses
//
// Purpose: turns one CPU dbus transaction into one single-beat cbus transaction,
// one outstanding at a time, with a registered response.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   dreq   - CPU request (valid held until addr_ok)
//   dresp  - addr_ok / data_ok / read data
//   creq   - request towards cbus arbiter
//   cresp  - ready / last / read data from cbus
module dbus_uncached_bridge
  import dbus_uncached_bridge_pkg::*;
#(
  parameter bit ALLOW_BACK_TO_BACK = 1'b1,
  parameter bit ALIGN_ADDR         = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  ubridge_state_t    r_state;
  ubridge_state_t    w_next;
  logic              w_accept;
  logic              w_capture;

  logic              r_is_write;
  msize_t            r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [STRB_W-1:0] r_strobe;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= UB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    dresp         = '0;
    dresp.data    = r_rdata;
    case (r_state)
      UB_IDLE: begin
        if (dreq.valid) begin
          w_accept = 1'b1;
          w_next   = UB_REQ;
        end
      end
      UB_REQ: begin
        if (cresp.ready) begin
          w_capture = 1'b1;
          if (cresp.last) begin
            w_next = UB_DONE;
          end
        end
      end
      UB_DONE: begin
        dresp.data_ok = 1'b1;
        if (ALLOW_BACK_TO_BACK && dreq.valid) begin
          w_accept = 1'b1;
          w_next   = UB_REQ;
        end else begin
          w_next = UB_IDLE;
        end
      end
      default: begin
        w_next = UB_IDLE;
      end
    endcase
    // addr_ok is combinational from dreq.valid; keep it low while reset is held
    // so every dresp output reads zero during reset.
    dresp.addr_ok = w_accept & ~reset;
  end

  // Request register: written only on acceptance, so dreq activity during REQ
  // cannot disturb the outstanding cbus request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_size     <= MSIZE1;
      r_addr     <= '0;
      r_strobe   <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_is_write <= |dreq.strobe;
      r_size     <= dreq.size;
      r_addr     <= dreq.addr;
      r_strobe   <= dreq.strobe;
      r_wdata    <= dreq.data;
    end
  end

  // Response register: holds its value outside DONE; writes return zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= r_is_write ? '0 : cresp.data;
    end
  end

  always_comb begin
    creq = '0;
    if (r_state == UB_REQ) begin
      creq.valid    = 1'b1;
      creq.is_write = r_is_write;
      creq.size     = ALIGN_ADDR ? MSIZE8 : r_size;
      creq.addr     = ALIGN_ADDR ? {r_addr[ADDR_W-1:3], 3'b000} : r_addr;
      creq.strobe   = r_strobe;
      creq.data     = r_wdata;
      creq.len      = MLEN1;
      creq.burst    = AXI_BURST_FIXED;
    end
  end

  // A single-beat request must finish on its first ready beat.
  a_single_beat: assert property (@(posedge clk) disable iff (reset)
    (r_state == UB_REQ && cresp.ready) |-> cresp.last);

endmodule

// File: tb/tb_dbus_uncached_bridge.sv
// tb/tb_dbus_uncached_bridge.sv - directed self-checking bench for dbus_uncached_bridge
module tb_dbus_uncached_bridge;
  import dbus_uncached_bridge_pkg::*;

  logic       clk;
  logic       rst;
  dbus_req_t  dreq_a, dreq_b;
  dbus_resp_t dresp_a, dresp_b;
  cbus_req_t  creq_a, creq_b;
  cbus_resp_t cresp_a, cresp_b;

  int n_tests;
  int n_fail;

  dbus_uncached_bridge #(.ALLOW_BACK_TO_BACK(1'b1), .ALIGN_ADDR(1'b0)) dut_a (
    .clk(clk), .reset(rst), .dreq(dreq_a), .dresp(dresp_a), .creq(creq_a), .cresp(cresp_a)
  );

  dbus_uncached_bridge #(.ALLOW_BACK_TO_BACK(1'b1), .ALIGN_ADDR(1'b1)) dut_b (
    .clk(clk), .reset(rst), .dreq(dreq_b), .dresp(dresp_b), .creq(creq_b), .cresp(cresp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_creq(input string tag, input cbus_req_t obs, input cbus_req_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cbus_req_t mk_creq(input logic w, input msize_t sz, input logic [63:0] a,
                                        input logic [7:0] st, input logic [63:0] d);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = sz;
    r.addr     = a;
    r.strobe   = st;
    r.data     = d;
    r.len      = MLEN1;
    r.burst    = AXI_BURST_FIXED;
    return r;
  endfunction

  function automatic dbus_req_t mk_dreq(input logic [63:0] a, input msize_t sz,
                                        input logic [7:0] st, input logic [63:0] d);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = a;
    r.size   = sz;
    r.strobe = st;
    r.data   = d;
    return r;
  endfunction

  function automatic cbus_resp_t beat(input logic [63:0] d);
    cbus_resp_t r;
    r.ready = 1'b1;
    r.last  = 1'b1;
    r.data  = d;
    return r;
  endfunction

  cbus_req_t exp_c;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    dreq_a  = '0;
    dreq_b  = '0;
    cresp_a = '0;
    cresp_b = '0;

    // Reset state
    #1;
    chk("rst_dresp_a", 64'(dresp_a), 64'd0);
    chk("rst_creq_valid_a", 64'(creq_a.valid), 64'd0);
    chk_creq("rst_creq_a", creq_a, '0);
    chk_creq("rst_creq_b", creq_b, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: read, slave answers two cycles after creq.valid
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0008, MSIZE4, 8'h00, 64'd0);
    #1;
    chk("t1_addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    chk("t1_creq_idle", 64'(creq_a.valid), 64'd0);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    #1;
    chk_creq("t1_creq", creq_a, mk_creq(1'b0, MSIZE4, 64'h0000_0000_1000_0008, 8'h00, 64'd0));
    chk("t1_no_addr_ok_req", 64'(dresp_a.addr_ok), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_wait_data_ok", 64'(dresp_a.data_ok), 64'd0);
    @(negedge clk);
    cresp_a = beat(64'hDEAD_BEEF_0000_1111);
    @(negedge clk);
    cresp_a = '0;
    #1;
    chk("t1_data_ok", 64'(dresp_a.data_ok), 64'd1);
    chk("t1_data", dresp_a.data, 64'hDEAD_BEEF_0000_1111);
    chk("t1_creq_dropped", 64'(creq_a.valid), 64'd0);
    @(negedge clk);
    #1;
    chk("t1_data_ok_once", 64'(dresp_a.data_ok), 64'd0);
    chk("t1_data_hold", dresp_a.data, 64'hDEAD_BEEF_0000_1111);

    // 2: write returns zero data
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0004, MSIZE4, 8'hF0, 64'h1234_5678_0000_0000);
    #1;
    chk("t2_addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    cresp_a = beat(64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    chk_creq("t2_creq", creq_a,
             mk_creq(1'b1, MSIZE4, 64'h0000_0000_1000_0004, 8'hF0, 64'h1234_5678_0000_0000));
    @(negedge clk);
    cresp_a = '0;
    #1;
    chk("t2_data_ok", 64'(dresp_a.data_ok), 64'd1);
    chk("t2_data_zero", dresp_a.data, 64'd0);

    // 3: back-to-back, second request presented in the DONE cycle
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0010, MSIZE8, 8'h00, 64'd0);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    cresp_a = beat(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    cresp_a = '0;
    dreq_a = mk_dreq(64'h0000_0000_1000_0018, MSIZE8, 8'hFF, 64'hAAAA_5555_AAAA_5555);
    #1;
    chk("t3_data_ok", 64'(dresp_a.data_ok), 64'd1);
    chk("t3_addr_ok_with_data_ok", 64'(dresp_a.addr_ok), 64'd1);
    chk("t3_data", dresp_a.data, 64'h0123_4567_89AB_CDEF);
    chk("t3_creq_gap", 64'(creq_a.valid), 64'd0);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    #1;
    chk_creq("t3_creq2", creq_a,
             mk_creq(1'b1, MSIZE8, 64'h0000_0000_1000_0018, 8'hFF, 64'hAAAA_5555_AAAA_5555));
    chk("t3_no_data_ok", 64'(dresp_a.data_ok), 64'd0);
    cresp_a = beat(64'h1111_2222_3333_4444);
    @(negedge clk);
    cresp_a = '0;
    #1;
    chk("t3_data_ok2", 64'(dresp_a.data_ok), 64'd1);
    chk("t3_data2_zero", dresp_a.data, 64'd0);

    // 4: slave stall with dreq fields toggling
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0020, MSIZE4, 8'h00, 64'd0);
    #1;
    chk("t4_addr_ok", 64'(dresp_a.addr_ok), 64'd1);
    exp_c = mk_creq(1'b0, MSIZE4, 64'h0000_0000_1000_0020, 8'h00, 64'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dreq_a.valid  = ~i[0];
      dreq_a.addr   = {$urandom, $urandom};
      dreq_a.strobe = i[7:0] + 8'h01;
      dreq_a.data   = {$urandom, $urandom};
      dreq_a.size   = MSIZE8;
      #1;
      chk_creq("t4_creq_stable", creq_a, exp_c);
      chk("t4_no_addr_ok", 64'(dresp_a.addr_ok), 64'd0);
      chk("t4_no_data_ok", 64'(dresp_a.data_ok), 64'd0);
    end
    @(negedge clk);
    dreq_a.valid = 1'b0;
    cresp_a = beat(64'h5555_6666_7777_8888);
    #1;
    chk_creq("t4_creq_at_ready", creq_a, exp_c);
    @(negedge clk);
    cresp_a = '0;
    #1;
    chk("t4_data_ok", 64'(dresp_a.data_ok), 64'd1);
    chk("t4_data", dresp_a.data, 64'h5555_6666_7777_8888);
    @(negedge clk);
    #1;
    chk("t4_single_data_ok", 64'(dresp_a.data_ok), 64'd0);

    // 5: asynchronous reset in the middle of REQ, away from a clock edge
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0030, MSIZE4, 8'h00, 64'd0);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    #1;
    chk("t5_in_req", 64'(creq_a.valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_creq_valid", 64'(creq_a.valid), 64'd0);
    chk("t5_rst_dresp", 64'(dresp_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dreq_a = mk_dreq(64'h0000_0000_1000_0038, MSIZE4, 8'h00, 64'd0);
    #1;
    chk("t5_addr_ok_after", 64'(dresp_a.addr_ok), 64'd1);
    @(negedge clk);
    dreq_a.valid = 1'b0;
    #1;
    chk_creq("t5_creq_after", creq_a, mk_creq(1'b0, MSIZE4, 64'h0000_0000_1000_0038, 8'h00, 64'd0));
    cresp_a = beat(64'h0F0F_0F0F_F0F0_F0F0);
    @(negedge clk);
    cresp_a = '0;
    #1;
    chk("t5_data_ok_after", 64'(dresp_a.data_ok), 64'd1);
    chk("t5_data_after", dresp_a.data, 64'h0F0F_0F0F_F0F0_F0F0);

    // 6: address alignment instance
    @(negedge clk);
    dreq_b = mk_dreq(64'h0000_0000_1000_0006, MSIZE2, 8'h40, 64'h00AB_0000_0000_0000);
    #1;
    chk("t6_addr_ok", 64'(dresp_b.addr_ok), 64'd1);
    @(negedge clk);
    dreq_b.valid = 1'b0;
    #1;
    chk_creq("t6_creq_aligned", creq_b,
             mk_creq(1'b1, MSIZE8, 64'h0000_0000_1000_0000, 8'h40, 64'h00AB_0000_0000_0000));
    cresp_b = beat(64'h9999_9999_9999_9999);
    @(negedge clk);
    cresp_b = '0;
    #1;
    chk("t6_data_ok", 64'(dresp_b.data_ok), 64'd1);
    chk("t6_data_zero", dresp_b.data, 64'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
